// File: rtl/code_lock_fsm_if.sv
// Keypad lock bus: debounced switch/button inputs toward the controller,
// lock status and seven-segment text back toward the board.
interface code_lock_fsm_if #(
    parameter int unsigned DIGIT_W   = 4,
    parameter int unsigned MAX_TRIES = 3
);
    localparam int unsigned TRIES_W = $clog2(MAX_TRIES + 1);

    logic [DIGIT_W-1:0] sw;
    logic               enter_n;
    logic               clear_n;
    logic               unlocked;
    logic               alarm;
    logic [TRIES_W-1:0] tries_left;
    logic [6:0]         hex3;
    logic [6:0]         hex2;
    logic [6:0]         hex1;
    logic [6:0]         hex0;

    modport master (
        output sw, enter_n, clear_n,
        input  unlocked, alarm, tries_left, hex3, hex2, hex1, hex0
    );

    modport slave (
        input  sw, enter_n, clear_n,
        output unlocked, alarm, tries_left, hex3, hex2, hex1, hex0
    );
endinterface

// File: rtl/code_lock_fsm.sv
// Multi-digit keypad lock: digit entry, code compare, timed open window and
// status text on four HEX digits. Define LOCKOUT_EN for failed-attempt lockout.
module code_lock_fsm #(
    parameter int unsigned               DIGITS      = 4,
    parameter int unsigned               DIGIT_W     = 4,
    parameter logic [DIGITS*DIGIT_W-1:0] CODE        = 16'h1905,
    parameter int unsigned               MAX_TRIES   = 3,
    parameter int unsigned               OPEN_CYCLES = 250_000_000,
    parameter int unsigned               LOCK_CYCLES = 500_000_000
) (
    input  logic            clk,
    input  logic            reset,
    code_lock_fsm_if.slave  bus
);
    localparam int unsigned CODE_W    = DIGITS * DIGIT_W;
    localparam int unsigned CNT_W     = $clog2(DIGITS + 1);
    localparam int unsigned TRIES_W   = $clog2(MAX_TRIES + 1);
    localparam int unsigned TIMER_MAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int unsigned TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
    localparam int unsigned VIEW_BASE = (DIGITS > 4) ? DIGITS - 4 : 0;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ENTRY   = 3'd1;
    localparam logic [2:0] S_CHECK   = 3'd2;
    localparam logic [2:0] S_OPEN    = 3'd3;
    localparam logic [2:0] S_FAIL    = 3'd4;
`ifdef LOCKOUT_EN
    localparam logic [2:0] S_LOCKOUT = 3'd5;
`endif

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_UNDER = 7'b1110111;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0][6:0] TXT_OPEN = {7'b1000000, 7'b0001100, 7'b0000110, 7'b0101011};
    localparam logic [3:0][6:0] TXT_FAIL = {7'b0000110, 7'b0101111, 7'b0101111, 7'b0100011};
`ifdef LOCKOUT_EN
    localparam logic [3:0][6:0] TXT_LOCK = {7'b1000111, 7'b1000000, 7'b1000110, 7'b0111111};
`endif

    logic [2:0]         enter_sh, clear_sh;
    logic               enter_p, clear_p;
    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CODE_W-1:0]  code_q, code_d, code_shift;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               unlocked_q;
    logic [3:0][6:0]    hex_q, hex_d;
    logic [6:0]         seg;
    int unsigned        pos;
`ifdef LOCKOUT_EN
    logic [TRIES_W-1:0] tries_q, tries_d;
    logic               alarm_q;
`endif

    // Two sync flops plus one history flop; a press is the 1->0 step of the synced level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            enter_sh <= '1;
            clear_sh <= '1;
        end else begin
            enter_sh <= {enter_sh[1:0], bus.enter_n};
            clear_sh <= {clear_sh[1:0], bus.clear_n};
        end
    end

    assign enter_p = enter_sh[2] & ~enter_sh[1];
    assign clear_p = clear_sh[2] & ~clear_sh[1];

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        code_d     = code_q;
        timer_d    = timer_q;
`ifdef LOCKOUT_EN
        tries_d    = tries_q;
`endif
        code_shift = (code_q << DIGIT_W) | CODE_W'(bus.sw);
        case (state_q)
            S_IDLE: begin
                if (!clear_p && enter_p) begin
                    code_d  = code_shift;
                    count_d = CNT_W'(1);
                    state_d = (DIGITS == 1) ? S_CHECK : S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (clear_p) begin
                    state_d = S_IDLE;
                    count_d = '0;
                    code_d  = '0;
                end else if (enter_p) begin
                    code_d  = code_shift;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(DIGITS - 1))
                        state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                count_d = '0;
                code_d  = '0;
                if (code_q == CODE) begin
                    state_d = S_OPEN;
                    timer_d = TIMER_W'(OPEN_CYCLES - 1);
`ifdef LOCKOUT_EN
                    tries_d = TRIES_W'(MAX_TRIES);
`endif
                end else begin
`ifdef LOCKOUT_EN
                    tries_d = tries_q - TRIES_W'(1);
                    if (tries_q == TRIES_W'(1)) begin
                        state_d = S_LOCKOUT;
                        timer_d = TIMER_W'(LOCK_CYCLES - 1);
                    end else begin
                        state_d = S_FAIL;
                    end
`else
                    state_d = S_FAIL;
`endif
                end
            end
            S_OPEN: begin
                if (timer_q == '0)
                    state_d = S_IDLE;
                else
                    timer_d = timer_q - TIMER_W'(1);
            end
            S_FAIL: begin
                if (enter_p || clear_p)
                    state_d = S_IDLE;
            end
`ifdef LOCKOUT_EN
            S_LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d = S_IDLE;
                    tries_d = TRIES_W'(MAX_TRIES);
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Display is derived from the next state so text changes on the same edge as the state.
    always_comb begin
        hex_d = {4{SEG_DASH}};
        seg   = SEG_BLANK;
        pos   = 0;
        case (state_d)
            S_ENTRY, S_CHECK: begin
                for (int unsigned i = 0; i < 4; i++) begin
                    pos   = VIEW_BASE + i;
                    seg   = (pos < DIGITS && pos < 32'(count_d)) ? SEG_UNDER : SEG_BLANK;
                    hex_d = {hex_d[2:0], seg};
                end
            end
            S_OPEN:    hex_d = TXT_OPEN;
            S_FAIL:    hex_d = TXT_FAIL;
`ifdef LOCKOUT_EN
            S_LOCKOUT: hex_d = TXT_LOCK;
`endif
            default:   hex_d = {4{SEG_DASH}};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            code_q     <= '0;
            timer_q    <= '0;
            unlocked_q <= 1'b0;
            hex_q      <= {4{SEG_DASH}};
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            code_q     <= code_d;
            timer_q    <= timer_d;
            unlocked_q <= (state_d == S_OPEN);
            hex_q      <= hex_d;
        end
    end

`ifdef LOCKOUT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            tries_q <= TRIES_W'(MAX_TRIES);
            alarm_q <= 1'b0;
        end else begin
            tries_q <= tries_d;
            alarm_q <= (state_d == S_LOCKOUT);
        end
    end

    assign bus.tries_left = tries_q;
    assign bus.alarm      = alarm_q;
`else
    assign bus.tries_left = TRIES_W'(MAX_TRIES);
    assign bus.alarm      = 1'b0;
`endif

    assign bus.unlocked = unlocked_q;
    assign bus.hex3     = hex_q[3];
    assign bus.hex2     = hex_q[2];
    assign bus.hex1     = hex_q[1];
    assign bus.hex0     = hex_q[0];
endmodule

// File: tb/tb_code_lock_fsm.sv
// Bench for code_lock_fsm: vector table, multi-cycle corner sequences and a
// randomized press sequence against a digit-queue reference model.
module tb_code_lock_fsm;
    localparam int unsigned DIGITS      = 2;
    localparam int unsigned DIGIT_W     = 4;
    localparam logic [7:0]  CODE        = 8'h19;
    localparam int unsigned MAX_TRIES   = 2;
    localparam int unsigned OPEN_CYCLES = 8;
    localparam int unsigned LOCK_CYCLES = 16;

    localparam logic [6:0]  DASH  = 7'b0111111;
    localparam logic [6:0]  UNDER = 7'b1110111;
    localparam logic [6:0]  BLANK = 7'h7F;
    localparam logic [27:0] TXT_IDLE = {DASH, DASH, DASH, DASH};
    localparam logic [27:0] TXT_ONE  = {UNDER, BLANK, BLANK, BLANK};
    localparam logic [27:0] TXT_OPEN = {7'b1000000, 7'b0001100, 7'b0000110, 7'b0101011};
    localparam logic [27:0] TXT_ERR  = {7'b0000110, 7'b0101111, 7'b0101111, 7'b0100011};
    localparam logic [27:0] TXT_LOCK = {7'b1000111, 7'b1000000, 7'b1000110, 7'b0111111};
`ifdef LOCKOUT_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif
    localparam int T1 = LOCK_ON ? 1 : 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    code_lock_fsm_if #(.DIGIT_W(DIGIT_W), .MAX_TRIES(MAX_TRIES)) bus ();

    code_lock_fsm #(
        .DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .CODE(CODE), .MAX_TRIES(MAX_TRIES),
        .OPEN_CYCLES(OPEN_CYCLES), .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [27:0] hex, input bit unl,
                                 input bit alm, input int tries);
        check({tag, " hex"}, 32'({bus.hex3, bus.hex2, bus.hex1, bus.hex0}), 32'(hex));
        check({tag, " unlocked"}, 32'(bus.unlocked), 32'(unl));
        check({tag, " alarm"}, 32'(bus.alarm), 32'(alm));
        check({tag, " tries"}, 32'(bus.tries_left), 32'(tries));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Pull the requested pins low for `hold` cycles, then let the press settle.
    task automatic press(input bit en, input bit cl, input logic [3:0] d, input int hold);
        @(negedge clk);
        bus.sw = d;
        if (en) bus.enter_n = 1'b0;
        if (cl) bus.clear_n = 1'b0;
        repeat (hold) @(negedge clk);
        bus.enter_n = 1'b1;
        bus.clear_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Reference model: queue of entered digits plus a coarse mode.
    typedef enum int {M_IDLE, M_ENTRY, M_BAD, M_OPEN, M_LOCK} mode_t;
    mode_t      m_mode;
    int         m_tries;
    logic [3:0] m_q[$];

    function automatic logic [27:0] m_hex();
        logic [27:0] h;
        case (m_mode)
            M_ENTRY: begin
                h = {4{BLANK}};
                for (int i = 0; i < m_q.size() && i < 4; i++) h[27 - 7*i -: 7] = UNDER;
            end
            M_BAD:   h = TXT_ERR;
            M_OPEN:  h = TXT_OPEN;
            M_LOCK:  h = TXT_LOCK;
            default: h = TXT_IDLE;
        endcase
        return h;
    endfunction

    task automatic m_press(input bit en, input bit cl, input logic [3:0] d);
        int v;
        case (m_mode)
            M_IDLE, M_ENTRY: begin
                if (cl) begin
                    m_mode = M_IDLE;
                    m_q.delete();
                end else if (en) begin
                    m_q.push_back(d);
                    m_mode = M_ENTRY;
                    if (m_q.size() == DIGITS) begin
                        v = 0;
                        foreach (m_q[i]) v = v * 16 + int'(m_q[i]);
                        m_q.delete();
                        if (v == int'(CODE)) begin
                            m_mode  = M_OPEN;
                            m_tries = MAX_TRIES;
                        end else if (LOCK_ON) begin
                            m_tries--;
                            m_mode = (m_tries == 0) ? M_LOCK : M_BAD;
                        end else begin
                            m_mode = M_BAD;
                        end
                    end
                end
            end
            M_BAD:   if (en || cl) m_mode = M_IDLE;
            default: ;
        endcase
    endtask

    typedef struct {
        int          act;    // 0 enter, 1 clear, 2 both, 3 idle wait
        logic [3:0]  d;
        int          hold;
        logic [27:0] hex;
        bit          unl;
        int          tries;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int   n, first, acnt, r;
        bit   en, cl;
        logic [3:0] d;

        bus.sw = '0;
        bus.enter_n = 1'b1;
        bus.clear_n = 1'b1;

        vecs.push_back('{0, 4'd1, 1,   TXT_ONE,  1'b0, 2});
        vecs.push_back('{1, 4'd0, 1,   TXT_IDLE, 1'b0, 2});
        vecs.push_back('{0, 4'd1, 1,   TXT_ONE,  1'b0, 2});
        vecs.push_back('{2, 4'd9, 1,   TXT_IDLE, 1'b0, 2});
        vecs.push_back('{0, 4'd1, 100, TXT_ONE,  1'b0, 2});
        vecs.push_back('{0, 4'd9, 1,   TXT_OPEN, 1'b1, 2});
        vecs.push_back('{3, 4'd0, 20,  TXT_IDLE, 1'b0, 2});
        vecs.push_back('{0, 4'd1, 2,   TXT_ONE,  1'b0, 2});
        vecs.push_back('{0, 4'd8, 2,   TXT_ERR,  1'b0, T1});
        vecs.push_back('{0, 4'd5, 3,   TXT_IDLE, 1'b0, T1});
        vecs.push_back('{0, 4'd1, 1,   TXT_ONE,  1'b0, T1});
        vecs.push_back('{0, 4'd9, 5,   TXT_OPEN, 1'b1, 2});
        vecs.push_back('{3, 4'd0, 20,  TXT_IDLE, 1'b0, 2});
        vecs.push_back('{1, 4'd0, 1,   TXT_IDLE, 1'b0, 2});

        // Reset state
        do_reset();
        check_outputs("reset", TXT_IDLE, 1'b0, 1'b0, 2);

        // Correct code: open latency, text and exact window length
        press(1'b1, 1'b0, 4'd1, 1);
        @(negedge clk);
        bus.sw = 4'd9;
        bus.enter_n = 1'b0;
        n = 0;
        first = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 1) bus.enter_n = 1'b1;
            if (bus.unlocked) begin
                if (first < 0) begin
                    first = i;
                    check("open text", 32'({bus.hex3, bus.hex2, bus.hex1, bus.hex0}), 32'(TXT_OPEN));
                end
                n++;
            end
        end
        check("open latency", 32'(first), 32'd3);
        check("open length", 32'(n), 32'(OPEN_CYCLES));
        check_outputs("after open", TXT_IDLE, 1'b0, 1'b0, 2);

        // Vector table
        do_reset();
        foreach (vecs[k]) begin
            case (vecs[k].act)
                0: press(1'b1, 1'b0, vecs[k].d, vecs[k].hold);
                1: press(1'b0, 1'b1, vecs[k].d, vecs[k].hold);
                2: press(1'b1, 1'b1, vecs[k].d, vecs[k].hold);
                default: repeat (vecs[k].hold) @(negedge clk);
            endcase
            check_outputs($sformatf("vec%0d", k), vecs[k].hex, vecs[k].unl, 1'b0, vecs[k].tries);
        end

        // Two wrong codes: lockout window, ignored press, tries restored
        do_reset();
        press(1'b1, 1'b0, 4'd1, 1);
        press(1'b1, 1'b0, 4'd8, 1);
        check_outputs("wrong1", TXT_ERR, 1'b0, 1'b0, T1);
        press(1'b1, 1'b0, 4'd0, 1);
        press(1'b1, 1'b0, 4'd2, 1);
        @(negedge clk);
        bus.sw = 4'd3;
        bus.enter_n = 1'b0;
        acnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 1) bus.enter_n = 1'b1;
            if (bus.alarm) begin
                acnt++;
                if (acnt == 1)
                    check("lock text", 32'({bus.hex3, bus.hex2, bus.hex1, bus.hex0}), 32'(TXT_LOCK));
                if (acnt == 3) begin
                    bus.sw = 4'd1;
                    bus.enter_n = 1'b0;
                end
                if (acnt == 6) bus.enter_n = 1'b1;
            end
        end
        bus.enter_n = 1'b1;
        check("alarm length", 32'(acnt), LOCK_ON ? 32'(LOCK_CYCLES) : 32'd0);
        check_outputs("after wrong2", LOCK_ON ? TXT_IDLE : TXT_ERR, 1'b0, 1'b0, 2);
        press(1'b0, 1'b1, 4'd0, 1);
        check_outputs("back idle", TXT_IDLE, 1'b0, 1'b0, 2);

        // Reset asserted in the third open cycle
        press(1'b1, 1'b0, 4'd1, 1);
        @(negedge clk);
        bus.sw = 4'd9;
        bus.enter_n = 1'b0;
        first = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 1) bus.enter_n = 1'b1;
            if (bus.unlocked && first < 0) first = i;
            if (first >= 0 && i == first + 2) begin
                reset = 1'b0;
                break;
            end
        end
        bus.enter_n = 1'b1;
        check("open before reset", 32'(first), 32'd3);
        @(negedge clk);
        check_outputs("reset mid open", TXT_IDLE, 1'b0, 1'b0, 2);
        reset = 1'b1;
        @(negedge clk);

        // Randomized presses against the reference model
        do_reset();
        m_mode  = M_IDLE;
        m_tries = MAX_TRIES;
        m_q.delete();
        for (int it = 0; it < 80; it++) begin
            if (m_mode == M_OPEN || m_mode == M_LOCK) begin
                repeat (20) @(negedge clk);
                if (m_mode == M_LOCK) m_tries = MAX_TRIES;
                m_mode = M_IDLE;
            end else begin
                r  = int'($urandom_range(0, 9));
                en = (r != 0);
                cl = (r <= 1);
                r  = int'($urandom_range(0, 3));
                d  = (r == 0) ? 4'd1 : (r == 1) ? 4'd9 : 4'($urandom_range(0, 15));
                press(en, cl, d, int'($urandom_range(1, 5)));
                m_press(en, cl, d);
            end
            check_outputs($sformatf("rand%0d", it), m_hex(), m_mode == M_OPEN,
                          m_mode == M_LOCK, m_tries);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/code_lock_fsm.md
# code_lock_fsm

Parametrised multi-digit keypad lock controller for the DE2 lock prototype: accepts a DIGITS-long code, one digit per press of the enter button, from the slide switches. It compares the code against a compile-time constant and drives the unlock output with a timed open window. It counts failed attempts, with optional alarm lockout, and drives four active-low seven-segment digits with status text. It sits between the debounced board buttons/switches and the LED/HEX outputs, replacing single-shot combinational password checking.

## Interface
- DIGITS, 4, code length in digits (1..8)
- DIGIT_W, 4, bits per digit (switch width)
- CODE, 16'h1905, secret; DIGITS*DIGIT_W bits, digit 0 in MSBs (first entered)
- MAX_TRIES, 3, failed attempts allowed before lockout (>=1)
- OPEN_CYCLES, 250_000_000, clocks the lock stays open
- LOCK_CYCLES, 500_000_000, clocks of lockout
- clk  in  1  50 MHz system clock
- reset  in  1  reset, synchronous, active-low
- sw  in  DIGIT_W  digit value, sampled on enter press
- enter_n  in  1  enter button, active-low, asynchronous to clk
- clear_n  in  1  clear button, active-low, asynchronous to clk
- unlocked  out  1  high while state OPEN
- alarm  out  1  high while state LOCKOUT
- tries_left  out  $clog2(MAX_TRIES+1)  remaining attempts
- hex3..hex0  out  7 each  segments, active-low, bit0=a .. bit6=g; hex3 leftmost

## Operation
- Buttons: two-flop synchroniser each, then falling-edge detect → single-cycle press pulse; held button = one press.
- States: IDLE, ENTRY, CHECK, OPEN, FAIL, LOCKOUT.
- IDLE: enter press → shift sw into code register, digit count=1, go ENTRY (or CHECK if DIGITS=1).
- ENTRY: enter press → shift sw in, count+1; on DIGITS-th digit go CHECK. clear press → IDLE, count=0, code register zeroed, tries unchanged.
- CHECK (1 cycle): match → OPEN, load timer OPEN_CYCLES-1, tries_left=MAX_TRIES. Mismatch → tries_left-1; if result 0 → LOCKOUT (timer LOCK_CYCLES-1), else FAIL.
- OPEN: timer counts down; at 0 → IDLE. Buttons ignored.
- FAIL: wait; enter or clear press → IDLE (that press does not capture a digit).
- LOCKOUT: timer counts down, buttons ignored; at 0 → IDLE, tries_left=MAX_TRIES.
- Display: IDLE "----" (7'b0111111 each); ENTRY: positions 0..count-1 '_' (7'b1110111) from left, rest blank (7'h7F); OPEN "OPEn" (1000000,0001100,0000110,0101011); FAIL "Erro" (0000110,0101111,0101111,0100011); LOCKOUT "LOC-" (1000111,1000000,1000110,0111111).
- DIGITS<4: unused right digits blank in ENTRY; text states unchanged. DIGITS>4: ENTRY shows last 4 positions.
- Simultaneous enter and clear press: clear wins.

## Timing
- Reset values: state IDLE, unlocked=0, alarm=0, tries_left=MAX_TRIES, hex3..hex0=7'b0111111, code register 0, count 0, timer 0.
- All outputs registered; reset has priority over everything, including mid-OPEN/LOCKOUT (open/alarm drop next edge).
- Pin falling edge → press pulse after 2–3 clks; state/display update 1 clk after pulse.
- Last digit press pulse → CHECK next clk → OPEN/FAIL/LOCKOUT and outputs the clk after.
- OPEN lasts exactly OPEN_CYCLES clks of unlocked=1; LOCKOUT exactly LOCK_CYCLES clks of alarm=1.
- Timer width $clog2(max(OPEN_CYCLES,LOCK_CYCLES)); no wrap, stops at 0.

## Configuration
- LOCKOUT_EN defined: failed-attempt counting and LOCKOUT as above.
- LOCKOUT_EN undefined: LOCKOUT state and its timer not built; mismatch always → FAIL; tries_left constant MAX_TRIES; alarm tied 0.

## Test plan
Params DIGITS=2, DIGIT_W=4, CODE=8'h19, MAX_TRIES=2, OPEN_CYCLES=8, LOCK_CYCLES=16.
- Reset then press 1, 9 → unlocked=1 for exactly 8 clks, hex="OPEn", then IDLE "----", tries_left=2.
- Press 1, 8 → FAIL "Erro", tries_left=1, unlocked=0; press enter → IDLE, no digit captured.
- Two wrong codes (LOCKOUT_EN) → alarm=1 for 16 clks, "LOC-", presses ignored, then tries_left=2; without macro → FAIL, tries_left=2, alarm=0.
- Press 1, then clear → IDLE, count 0; then 1, 9 → OPEN (partial entry discarded).
- Enter and clear pressed same clk in ENTRY → IDLE; enter held 100 clks → one digit only.
- reset low during OPEN (clk 3) → next edge unlocked=0, IDLE, tries_left=2, display "----".
